// File: rtl/core_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// core_ctrl_pkg
// Shared definitions for the core run/halt/single-step clock controller.
//   core_state_e : controller state encoding, also exported on the `state` port
//                  (2'd3 is unused and recovers to HALT).
//   EN_COUNT_W   : width of the retired-enable counter.
// ----------------------------------------------------------------------------
package core_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_HALT = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2
    } core_state_e;

    localparam int EN_COUNT_W = 16;

endpackage : core_ctrl_pkg

// File: rtl/btn_debounce.sv
// ----------------------------------------------------------------------------
// btn_debounce
// Conditions one raw asynchronous push-button: 2-flop synchronizer, a
// stability counter, and a one-cycle pulse on each accepted press.
//   clk       : system clock
//   reset     : synchronous, active-high
//   btn_raw   : raw button level, asynchronous to clk
//   btn_level : debounced level
//   btn_rise  : one-cycle pulse when btn_level goes 0 -> 1
// A clean raw edge produces btn_rise 2 + DEBOUNCE_CYCLES cycles later.
// ----------------------------------------------------------------------------
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_rise
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic          level_q, level_d;
    logic          rise_q,  rise_d;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and a latch is never inferred.
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        cnt_d   = '0;
        level_d = level_q;
        rise_d  = 1'b0;
        if (sync2_q != level_q) begin
            // The sample that completes the run flips the level directly,
            // so the counter only needs to reach DEBOUNCE_CYCLES-1.
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                rise_d  = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
        end
    end

    assign btn_level = level_q;
    assign btn_rise  = rise_q;

endmodule : btn_debounce

// File: rtl/core_clk_ctrl.sv
// ----------------------------------------------------------------------------
// core_clk_ctrl
// Run/halt/single-step controller producing a one-cycle clock-enable pulse
// for the RISC-V core.
//   clk      : 50 MHz system clock
//   reset    : synchronous, active-high
//   run_btn  : raw button, selects RUN (periodic enable)
//   step_btn : raw button, one enable pulse per press from HALT
//   halt_btn : raw button, selects HALT (no enable)
//   core_en  : registered one-cycle enable to the core
//   state    : current state (0 = HALT, 1 = RUN, 2 = STEP)
//   running  : high while in RUN
//   en_count : core_en pulses since reset, wrapping
// Simultaneous button events resolve halt > step > run.
// ----------------------------------------------------------------------------
module core_clk_ctrl
    import core_ctrl_pkg::*;
#(
    parameter int DIV_VALUE       = 10000000,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int RESET_RUN       = 1,
    parameter int CNT_W           = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run_btn,
    input  logic                  step_btn,
    input  logic                  halt_btn,
    output logic                  core_en,
    output logic [1:0]            state,
    output logic                  running,
    output logic [EN_COUNT_W-1:0] en_count
);

    localparam core_state_e      RESET_STATE = (RESET_RUN != 0) ? ST_RUN : ST_HALT;
    localparam logic [CNT_W-1:0] DIV_LAST    = CNT_W'(DIV_VALUE - 1);

    logic       run_evt, step_evt, halt_evt;
    logic [2:0] unused_levels;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_db (
        .clk(clk), .reset(reset), .btn_raw(run_btn),
        .btn_level(unused_levels[0]), .btn_rise(run_evt)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_db (
        .clk(clk), .reset(reset), .btn_raw(step_btn),
        .btn_level(unused_levels[1]), .btn_rise(step_evt)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_halt_db (
        .clk(clk), .reset(reset), .btn_raw(halt_btn),
        .btn_level(unused_levels[2]), .btn_rise(halt_evt)
    );

    core_state_e           state_q,    state_d;
    logic [CNT_W-1:0]      div_q,      div_d;
    logic                  core_en_q,  core_en_d;
    logic                  running_q,  running_d;
    logic [EN_COUNT_W-1:0] en_count_q, en_count_d;

    always_comb begin
        state_d    = state_q;
        div_d      = '0;
        core_en_d  = 1'b0;
        en_count_d = en_count_q + {{(EN_COUNT_W-1){1'b0}}, core_en_q};
        case (state_q)
            ST_HALT: begin
                if (halt_evt) begin
                    state_d = ST_HALT;
                end else if (step_evt) begin
                    // The single enable is issued in the STEP cycle itself.
                    state_d   = ST_STEP;
                    core_en_d = 1'b1;
                end else if (run_evt) begin
                    state_d = ST_RUN;
                end
            end
            ST_STEP: begin
                state_d = ST_HALT;
            end
            ST_RUN: begin
                // Halt is checked first so a halt on the terminal count
                // suppresses that cycle's pulse.
                if (halt_evt) begin
                    state_d = ST_HALT;
                end else if (div_q == DIV_LAST) begin
                    core_en_d = 1'b1;
                end else begin
                    div_d = div_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase
        running_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RESET_STATE;
            div_q      <= '0;
            core_en_q  <= 1'b0;
            running_q  <= (RESET_STATE == ST_RUN);
            en_count_q <= '0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            core_en_q  <= core_en_d;
            running_q  <= running_d;
            en_count_q <= en_count_d;
        end
    end

    assign core_en  = core_en_q;
    assign state    = state_q;
    assign running  = running_q;
    assign en_count = en_count_q;

endmodule : core_clk_ctrl

// File: tb/tb_core_clk_ctrl.sv
// ----------------------------------------------------------------------------
// tb_core_clk_ctrl
// Two controller instances: dut1 (DIV_VALUE=4) for the directed and random
// scenarios, dut2 (DIV_VALUE=1) to reach the en_count wrap quickly. Both are
// compared every cycle against a behavioural model that treats the debouncer
// as "N consecutive disagreeing samples" and the divider as "pulse whenever
// the time spent in RUN is a multiple of DIV_VALUE".
// ----------------------------------------------------------------------------
module tb_core_clk_ctrl;

    localparam int DEB = 3;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Button vectors: bit 0 = run, bit 1 = step, bit 2 = halt.
    logic        rst1, rst2;
    logic [2:0]  btn1, btn2;
    logic        core_en1, core_en2, running1, running2;
    logic [1:0]  state1, state2;
    logic [15:0] en_count1, en_count2;

    core_clk_ctrl #(.DIV_VALUE(4), .DEBOUNCE_CYCLES(DEB), .RESET_RUN(1), .CNT_W(8)) dut1 (
        .clk(clk), .reset(rst1),
        .run_btn(btn1[0]), .step_btn(btn1[1]), .halt_btn(btn1[2]),
        .core_en(core_en1), .state(state1), .running(running1), .en_count(en_count1)
    );

    core_clk_ctrl #(.DIV_VALUE(1), .DEBOUNCE_CYCLES(DEB), .RESET_RUN(1), .CNT_W(4)) dut2 (
        .clk(clk), .reset(rst2),
        .run_btn(btn2[0]), .step_btn(btn2[1]), .halt_btn(btn2[2]),
        .core_en(core_en2), .state(state2), .running(running2), .en_count(en_count2)
    );

    typedef struct packed {
        bit [1:0]            mode;     // 0 halt, 1 run, 2 step
        bit [31:0]           age;      // cycles spent in RUN since entry
        bit                  en;
        bit [15:0]           cnt;
        bit [2:0]            level;
        bit [2:0]            rise;
        bit [1:0][2:0]       raw_hist; // [0] raw one edge ago, [1] two edges ago
        bit [DEB-1:0][2:0]   win;      // most recent synchronized samples
    } model_t;

    model_t m1, m2;
    int     n_checks = 0;
    int     n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // One rising edge of the reference model.
    task automatic model_step(input model_t mi, input bit rst, input bit [2:0] raw,
                              input int div, input bit reset_run, output model_t mo);
        bit [2:0] evt;
        bit       all_diff;
        mo = mi;
        if (rst) begin
            mo      = '0;
            mo.mode = reset_run ? 2'd1 : 2'd0;
        end else begin
            evt = mi.rise;
            mo.win[0] = mi.raw_hist[1];
            for (int i = 1; i < DEB; i++) mo.win[i] = mi.win[i-1];
            for (int b = 0; b < 3; b++) begin
                all_diff = 1'b1;
                for (int i = 0; i < DEB; i++)
                    if (mo.win[i][b] == mi.level[b]) all_diff = 1'b0;
                mo.level[b] = mi.level[b] ^ all_diff;
                mo.rise[b]  = all_diff & ~mi.level[b];
            end
            mo.raw_hist[1] = mi.raw_hist[0];
            mo.raw_hist[0] = raw;
            mo.cnt = mi.cnt + 16'(mi.en);
            mo.en  = 1'b0;
            case (mi.mode)
                2'd0: begin
                    if (evt[2])      mo.mode = 2'd0;
                    else if (evt[1]) begin mo.mode = 2'd2; mo.en = 1'b1; end
                    else if (evt[0]) begin mo.mode = 2'd1; mo.age = 0; end
                end
                2'd1: begin
                    if (evt[2]) mo.mode = 2'd0;
                    else begin
                        mo.age = mi.age + 1;
                        mo.en  = ((mo.age % div) == 0);
                    end
                end
                default: mo.mode = 2'd0;
            endcase
        end
    endtask

    // Advance one cycle: model both DUTs at the edge, compare at the negedge.
    task automatic tick();
        @(posedge clk);
        model_step(m1, rst1, btn1, 4, 1'b1, m1);
        model_step(m2, rst2, btn2, 1, 1'b1, m2);
        @(negedge clk);
        check("d1_state",    32'(state1),    32'(m1.mode));
        check("d1_core_en",  32'(core_en1),  32'(m1.en));
        check("d1_running",  32'(running1),  32'(m1.mode == 2'd1));
        check("d1_en_count", 32'(en_count1), 32'(m1.cnt));
        check("d2_state",    32'(state2),    32'(m2.mode));
        check("d2_core_en",  32'(core_en2),  32'(m2.en));
        check("d2_en_count", 32'(en_count2), 32'(m2.cnt));
    endtask

    // Drive a mask on dut1 for `hold` cycles, release, and count pulses seen.
    task automatic press1(input bit [2:0] mask, input int hold, input int gap, output int pulses);
        pulses = 0;
        btn1 = mask;
        repeat (hold) begin tick(); pulses += int'(core_en1); end
        btn1 = 3'b000;
        repeat (gap) begin tick(); pulses += int'(core_en1); end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses, total, first, n, base;
        bit done;
        m1 = '0; m2 = '0;
        rst1 = 1'b1; rst2 = 1'b1; btn1 = '0; btn2 = '0;
        @(negedge clk);
        repeat (3) tick();
        check("reset_state",    32'(state1),    32'd1);
        check("reset_core_en",  32'(core_en1),  32'd0);
        check("reset_en_count", 32'(en_count1), 32'd0);
        rst1 = 1'b0; rst2 = 1'b0;

        // RUN from reset: pulse every 4th cycle, first after 4 cycles.
        pulses = 0; first = -1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (core_en1) begin
                pulses++;
                if (first < 0) first = i + 1;
            end
        end
        check("run_first_pulse", 32'(first),  32'd4);
        check("run_pulses_20",   32'(pulses), 32'd5);

        // Clean halt press: state drops on the 6th edge after the raw edge.
        btn1 = 3'b100; n = 0; done = 0;
        while (!done && n < 20) begin tick(); n++; done = (state1 == 2'd0); end
        check("halt_latency", 32'(n), 32'd6);
        btn1 = 3'b000;
        base = int'(en_count1);
        press1(3'b000, 0, 20, pulses);
        check("halt_no_pulse", 32'(pulses),    32'd0);
        check("halt_frozen",   32'(en_count1), 32'(base));

        // Three single steps.
        total = 0; base = int'(en_count1);
        for (int k = 0; k < 3; k++) begin
            press1(3'b010, 6, 14, pulses);
            total += pulses;
        end
        check("step_pulses", 32'(total), 32'd3);
        check("step_count",  32'(en_count1), 32'((base + 3) & 16'hFFFF));

        // Bouncing step press: 1,0,1,0 then held high.
        total = 0;
        btn1 = 3'b010; tick(); total += int'(core_en1);
        btn1 = 3'b000; tick(); total += int'(core_en1);
        btn1 = 3'b010; tick(); total += int'(core_en1);
        btn1 = 3'b000; tick(); total += int'(core_en1);
        press1(3'b010, 10, 12, pulses);
        total += pulses;
        check("bounce_pulses", 32'(total), 32'd1);

        // Run and halt together in HALT: halt wins.
        press1(3'b101, 8, 10, pulses);
        check("run_halt_pulses", 32'(pulses), 32'd0);
        check("run_halt_state",  32'(state1), 32'd0);

        // Halt landing on the terminal-count edge suppresses that pulse.
        press1(3'b001, 6, 0, pulses);
        n = 0;
        while (!(m1.mode == 2'd1 && (m1.age % 4) == 2) && n < 20) begin tick(); n++; end
        check("tc_align_timeout", 32'(n < 20), 32'd1);
        btn1 = 3'b100; pulses = 0;
        repeat (6) begin tick(); pulses += int'(core_en1); end
        btn1 = 3'b000;
        check("tc_halt_pulses",  32'(pulses),   32'd1);
        check("tc_halt_core_en", 32'(core_en1), 32'd0);
        check("tc_halt_state",   32'(state1),   32'd0);
        repeat (10) tick();

        // Randomized buttons, bounce and occasional resets.
        for (int it = 0; it < 150; it++) begin
            if ($urandom_range(0, 29) == 0) begin
                rst1 = 1'b1; tick(); rst1 = 1'b0;
            end
            n = $urandom_range(1, 12);
            if ($urandom_range(0, 3) == 0) begin
                repeat (n) begin btn1 = 3'($urandom); tick(); end
            end else begin
                btn1 = 3'($urandom_range(0, 7));
                repeat (n) tick();
            end
            btn1 = 3'b000;
            repeat ($urandom_range(0, 10)) tick();
        end
        repeat (12) tick();

        // Reset while in STEP.
        press1(3'b100, 6, 10, pulses);
        btn1 = 3'b010; n = 0;
        while (m1.mode != 2'd2 && n < 20) begin tick(); n++; end
        check("step_reach_timeout", 32'(n < 20), 32'd1);
        check("step_core_en", 32'(core_en1), 32'd1);
        rst1 = 1'b1;
        tick();
        check("rst_in_step_core_en", 32'(core_en1), 32'd0);
        check("rst_in_step_state",   32'(state1),   32'd1);
        rst1 = 1'b0; btn1 = 3'b000;

        // dut2 wrap: halt so the count freezes at 0xFFFE, then two steps.
        n = 0;
        while (m2.cnt != 16'hFFF8 && n < 70000) begin tick(); n++; end
        check("wrap_reach_timeout", 32'(n < 70000), 32'd1);
        btn2 = 3'b100;
        repeat (6) tick();
        check("wrap_halt_state", 32'(state2), 32'd0);
        btn2 = 3'b000;
        repeat (10) tick();
        check("wrap_preload", 32'(en_count2), 32'h0000_FFFE);
        for (int k = 0; k < 2; k++) begin
            btn2 = 3'b010; repeat (6) tick();
            btn2 = 3'b000; repeat (14) tick();
        end
        check("wrap_zero", 32'(en_count2), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_core_clk_ctrl
